// File: rtl/frame_write_controller.sv
// Packs two pixels per SRAM word into the back frame of a double-buffered store; req one cycle after 2nd pixel.
// Backpressure: pix_ready low from REQUEST until two cycles after n_writedone ack (three when the frame swaps).
module frame_write_controller #(
  parameter int PIX_W    = 16,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                sof,
  input  logic                pix_valid,
  input  logic [PIX_W-1:0]    pix_data,
  output logic                pix_ready,
  output logic                write_req,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [2*PIX_W-1:0]  write_data,
  input  logic                n_writedone,
  output logic                frameswap,
  output logic                write_frame,
  output logic                frame_abort
);

  localparam int WORDS = H_ACTIVE * V_ACTIVE / 2;
  localparam logic [ADDR_W-2:0] LAST_WORD = (ADDR_W-1)'(WORDS - 1);
  localparam logic [ADDR_W-2:0] WORD_ONE  = (ADDR_W-1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER_LO,
    S_GATHER_HI,
    S_REQUEST,
    S_WAIT_ACK,
    S_ADVANCE,
    S_SWAP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-2:0] r_word_cnt, w_word_cnt_nxt;
  logic [PIX_W-1:0]  r_lo, w_lo_nxt;
  logic [PIX_W-1:0]  r_hi, w_hi_nxt;
  logic              r_write_frame, w_write_frame_nxt;
  logic              r_frame_abort, w_frame_abort_nxt;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state       <= S_IDLE;
      r_word_cnt    <= '0;
      r_lo          <= '0;
      r_hi          <= '0;
      r_write_frame <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_word_cnt    <= w_word_cnt_nxt;
      r_lo          <= w_lo_nxt;
      r_hi          <= w_hi_nxt;
      r_write_frame <= w_write_frame_nxt;
      r_frame_abort <= w_frame_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_word_cnt_nxt    = r_word_cnt;
    w_lo_nxt          = r_lo;
    w_hi_nxt          = r_hi;
    w_write_frame_nxt = r_write_frame;
    w_frame_abort_nxt = 1'b0;
    pix_ready         = 1'b0;
    write_req         = 1'b0;
    frameswap         = 1'b0;

    case (r_state)
      // Unsynchronised: swallow everything until a frame start arrives.
      S_IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid && sof) begin
          w_lo_nxt    = pix_data;
          w_state_nxt = S_GATHER_HI;
        end
      end
      S_GATHER_LO: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          w_lo_nxt    = pix_data;
          w_state_nxt = S_GATHER_HI;
          if (sof) begin
            w_frame_abort_nxt = 1'b1;
            w_word_cnt_nxt    = '0;
          end
        end
      end
      S_GATHER_HI: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          if (sof) begin
            w_frame_abort_nxt = 1'b1;
            w_word_cnt_nxt    = '0;
            w_lo_nxt          = pix_data;
          end else begin
            w_hi_nxt    = pix_data;
            w_state_nxt = S_REQUEST;
          end
        end
      end
      S_REQUEST: begin
        write_req   = 1'b1;
        w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!n_writedone) w_state_nxt = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (r_word_cnt == LAST_WORD) begin
          w_word_cnt_nxt = '0;
          w_state_nxt    = S_SWAP;
        end else begin
          w_word_cnt_nxt = r_word_cnt + WORD_ONE;
          w_state_nxt    = S_GATHER_LO;
        end
      end
      S_SWAP: begin
        frameswap         = 1'b1;
        w_write_frame_nxt = ~r_write_frame;
        w_state_nxt       = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign write_addr  = {r_write_frame, r_word_cnt};
  assign write_data  = {r_hi, r_lo};
  assign write_frame = r_write_frame;
  assign frame_abort = r_frame_abort;

endmodule

// File: tb/tb_frame_write_controller.sv
// Bench for frame_write_controller on a 4x2 frame (4 words): directed pairs, frame swap, abort, reset.
// A latency-rule model predicts every output each cycle; literal checks pin key values.
module tb_frame_write_controller;
  localparam int PIX_W = 16;
  localparam int H_ACTIVE = 4;
  localparam int V_ACTIVE = 2;
  localparam int ADDR_W = 19;
  localparam int WORDS = H_ACTIVE * V_ACTIVE / 2;

  logic                clk;
  logic                n_rst;
  logic                sof;
  logic                pix_valid;
  logic [PIX_W-1:0]    pix_data;
  logic                pix_ready;
  logic                write_req;
  logic [ADDR_W-1:0]   write_addr;
  logic [2*PIX_W-1:0]  write_data;
  logic                n_writedone;
  logic                frameswap;
  logic                write_frame;
  logic                frame_abort;

  frame_write_controller #(
    .PIX_W(PIX_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .n_rst(n_rst), .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .write_req(write_req), .write_addr(write_addr),
    .write_data(write_data), .n_writedone(n_writedone), .frameswap(frameswap),
    .write_frame(write_frame), .frame_abort(frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected writes are queued when a pair completes; busy/ack timing follows the latency rules.
  logic [ADDR_W+2*PIX_W-1:0] wq[$];
  logic [ADDR_W+2*PIX_W-1:0] last_wr;
  bit          m_live = 0, m_synced, m_have_lo, m_frame, m_busy, m_armed, m_acked, m_swap_pend, m_abort;
  logic [PIX_W-1:0] m_lo;
  int          m_word, m_rel, m_rel_init;

  task automatic model_reset();
    m_synced = 0; m_have_lo = 0; m_frame = 0; m_busy = 0; m_armed = 0; m_acked = 0;
    m_swap_pend = 0; m_abort = 0; m_lo = '0; m_word = 0; m_rel = 0; m_rel_init = 0;
    wq.delete();
  endtask

  task automatic model_accept(input bit s, input logic [PIX_W-1:0] d);
    if (!m_synced) begin
      if (s) begin m_synced = 1; m_lo = d; m_have_lo = 1; m_word = 0; end
    end else if (s) begin
      m_abort = 1; m_word = 0; m_lo = d; m_have_lo = 1;
    end else if (!m_have_lo) begin
      m_lo = d; m_have_lo = 1;
    end else begin
      wq.push_back({m_frame, (ADDR_W-1)'(m_word), d, m_lo});
      m_have_lo = 0; m_busy = 1; m_armed = 0; m_acked = 0;
      if (m_word == WORDS - 1) begin m_swap_pend = 1; m_synced = 0; m_word = 0; end
      else m_word++;
    end
  endtask

  always @(posedge clk) begin
    if (!n_rst) begin
      model_reset();
      m_live = 1;
    end else if (m_live) begin
      m_abort = 0;
      if (m_busy) begin
        if (!m_armed) m_armed = 1;
        else if (!m_acked) begin
          if (!n_writedone) begin
            m_acked = 1; m_rel = m_swap_pend ? 2 : 1; m_rel_init = m_rel;
          end
        end else begin
          m_rel--;
          if (m_rel == 0) begin
            m_busy = 0;
            if (m_swap_pend) begin m_frame = ~m_frame; m_swap_pend = 0; end
          end
        end
      end else if (pix_valid) begin
        model_accept(sof, pix_data);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("pix_ready", pix_ready, !m_busy);
      chk("write_req", write_req, m_busy && !m_armed);
      chk("frameswap", frameswap, m_busy && m_acked && m_swap_pend && m_rel == 1);
      chk("frame_abort", frame_abort, m_abort);
      chk("write_frame", write_frame, m_frame);
      if (m_busy && !m_armed && wq.size() > 0) begin
        last_wr = wq.pop_front();
        chk("req_addr", write_addr, last_wr[ADDR_W+2*PIX_W-1:2*PIX_W]);
        chk("req_data", write_data, last_wr[2*PIX_W-1:0]);
      end else if (m_busy && m_armed && (!m_acked || m_rel == m_rel_init)) begin
        chk("hold_addr", write_addr, last_wr[ADDR_W+2*PIX_W-1:2*PIX_W]);
        chk("hold_data", write_data, last_wr[2*PIX_W-1:0]);
      end
    end
  end

  // Called right after a negedge; returns at the negedge following acceptance.
  task automatic send(input bit s, input logic [PIX_W-1:0] d);
    int n = 0;
    pix_valid = 1'b1; sof = s; pix_data = d;
    while (!pix_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("send_timeout", 1, 0);
    @(negedge clk);
    pix_valid = 1'b0; sof = 1'b0;
  endtask

  // Called in the REQUEST cycle; acks after 'hold' WAIT_ACK cycles.
  task automatic ack(input int hold);
    @(negedge clk);
    repeat (hold) @(negedge clk);
    n_writedone = 1'b0;
    @(negedge clk);
    n_writedone = 1'b1;
  endtask

  task automatic pair(input bit s, input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                      input logic [ADDR_W-1:0] exp_addr);
    send(s, a);
    send(1'b0, b);
    chk("pair_req", write_req, 1);
    chk("pair_addr", write_addr, exp_addr);
    chk("pair_data", write_data, {b, a});
    ack(0);
  endtask

  task automatic reset_dut();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_data = '0; n_writedone = 1'b1;
    @(negedge clk);

    // 1: reset state
    reset_dut();
    chk("rst_write_req", write_req, 0);
    chk("rst_frameswap", frameswap, 0);
    chk("rst_write_frame", write_frame, 0);
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_write_data", write_data, 0);
    chk("rst_write_addr", write_addr, 0);

    // 2: single pair with slow ack; glitch on n_rst between edges must not reset
    send(1'b1, 16'h1111);
    #1 n_rst = 1'b0;
    #2 n_rst = 1'b1;
    send(1'b0, 16'h2222);
    chk("t2_req", write_req, 1);
    chk("t2_addr", write_addr, 19'h00000);
    chk("t2_data", write_data, 32'h22221111);
    @(negedge clk);
    repeat (4) begin
      chk("t2_wait_ready", pix_ready, 0);
      @(negedge clk);
    end
    n_writedone = 1'b0;
    @(negedge clk);
    n_writedone = 1'b1;
    pair(1'b0, 16'h3333, 16'h4444, 19'h00001);

    // 3: full frame then second frame in the other buffer
    reset_dut();
    pair(1'b1, 16'h0A01, 16'h0A02, 19'h00000);
    pair(1'b0, 16'h0A03, 16'h0A04, 19'h00001);
    pair(1'b0, 16'h0A05, 16'h0A06, 19'h00002);
    pair(1'b0, 16'h0A07, 16'h0A08, 19'h00003);
    @(negedge clk);
    chk("t3_swap", frameswap, 1);
    @(negedge clk);
    chk("t3_swap_end", frameswap, 0);
    chk("t3_frame", write_frame, 1);
    pair(1'b1, 16'h0B01, 16'h0B02, 19'h40000);

    // 6: reset while waiting for an ack in frame 1
    send(1'b0, 16'h0B03);
    send(1'b0, 16'h0B04);
    chk("t6_addr", write_addr, 19'h40001);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    chk("t6_ready", pix_ready, 1);
    chk("t6_req", write_req, 0);
    chk("t6_frame", write_frame, 0);
    n_rst = 1'b1;
    pair(1'b1, 16'h0C01, 16'h0C02, 19'h00000);

    // 4: abort after 3 words plus one pixel
    reset_dut();
    pair(1'b1, 16'h0D01, 16'h0D02, 19'h00000);
    pair(1'b0, 16'h0D03, 16'h0D04, 19'h00001);
    pair(1'b0, 16'h0D05, 16'h0D06, 19'h00002);
    send(1'b0, 16'h0D07);
    send(1'b1, 16'hAAAA);
    chk("t4_abort", frame_abort, 1);
    chk("t4_no_swap", frameswap, 0);
    send(1'b0, 16'hBBBB);
    chk("t4_addr", write_addr, 19'h00000);
    chk("t4_data", write_data, 32'hBBBBAAAA);
    ack(0);

    // 5: drop unsynced pixels, valid gaps, ack ignored during REQUEST
    reset_dut();
    send(1'b0, 16'hDEAD);
    send(1'b0, 16'hBEEF);
    repeat (3) @(negedge clk);
    chk("t5_no_req", write_req, 0);
    send(1'b1, 16'h00C1);
    sof = 1'b1; pix_data = 16'hFFFF;
    repeat (4) @(negedge clk);
    sof = 1'b0;
    send(1'b0, 16'h00C2);
    chk("t5_addr", write_addr, 19'h00000);
    chk("t5_data", write_data, 32'h00C200C1);
    n_writedone = 1'b0;
    @(negedge clk);
    n_writedone = 1'b1;
    repeat (3) begin
      chk("t5_still_wait", pix_ready, 0);
      @(negedge clk);
    end
    n_writedone = 1'b0;
    @(negedge clk);
    n_writedone = 1'b1;
    repeat (3) @(negedge clk);
    pair(1'b0, 16'h00C3, 16'h00C4, 19'h00001);
    repeat (3) @(negedge clk);

    chk("queue_empty", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_write_controller.md
Name: frame_write_controller

Overview:
- Write-side counterpart of the TMDS read controller. Accepts an incoming pixel stream, packs two pixels per SRAM word and issues write requests to the SRAM wrapper.
- Writes always target the back frame of a double-buffered 640x480 frame store. On frame completion it pulses frameswap so the display side flips to the newly written frame.

Parameters:
- PIX_W, 16, bits per pixel.
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- ADDR_W, 19, SRAM word address width. MSB is the frame select bit; the low ADDR_W-1 bits are the word index.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  synchronous active-low reset.
- sof  in  1  start-of-frame sideband. Qualified only by pix_valid & pix_ready.
- pix_valid  in  1  input pixel valid.
- pix_data  in  PIX_W  input pixel.
- pix_ready  out  1  block can accept a pixel this cycle.
- write_req  out  1  one-cycle write request pulse to the SRAM wrapper.
- write_addr  out  ADDR_W  {write_frame, word_cnt}.
- write_data  out  2*PIX_W  packed pixel pair.
- n_writedone  in  1  active-low write acknowledge from the SRAM wrapper.
- frameswap  out  1  one-cycle pulse when a full frame has been written.
- write_frame  out  1  frame select bit currently being written.
- frame_abort  out  1  one-cycle pulse when a frame is restarted by sof.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-low on n_rst.
- Reset state: IDLE. write_req=0, frameswap=0, frame_abort=0, write_frame=0, word_cnt=0, write_data=0, pix_ready=1.
- Handshakes: a pixel is accepted when pix_valid & pix_ready. WORDS = H_ACTIVE*V_ACTIVE/2 (153600 by default).
- Packing: the first pixel of a pair goes to write_data[PIX_W-1:0], the second to the upper half.
- IDLE:
  - pix_ready=1.
  - An accepted pixel with sof=1 is stored as the low half -> GATHER_HI.
  - Accepted pixels with sof=0 are dropped, so upstream never stalls while unsynchronised.
- GATHER_LO:
  - pix_ready=1.
  - Accepted pixel -> low half -> GATHER_HI.
  - If that pixel has sof=1: frame_abort=1 for one cycle, word_cnt<=0, pixel kept as pixel 0.
- GATHER_HI:
  - pix_ready=1.
  - Accepted pixel with sof=0 -> upper half -> REQUEST.
  - Accepted pixel with sof=1: frame_abort pulse, word_cnt<=0, pixel stored as new low half, stay in GATHER_HI.
- REQUEST:
  - write_req=1 for exactly one cycle; pix_ready=0 -> WAIT_ACK.
  - n_writedone is ignored in this state.
- WAIT_ACK:
  - pix_ready=0, write_req=0.
  - Stays until n_writedone==0, then -> ADVANCE.
  - No timeout.
- ADVANCE (one cycle, pix_ready=0):
  - If word_cnt==WORDS-1: word_cnt<=0 -> SWAP.
  - Otherwise: word_cnt<=word_cnt+1 -> GATHER_LO.
- SWAP (one cycle, pix_ready=0): frameswap=1, write_frame toggles -> IDLE.
- Data stability: write_addr and write_data hold stable from REQUEST until the cycle after the ack.
- sof outside accept cycles: ignored, because pix_ready=0 in REQUEST, WAIT_ACK, ADVANCE and SWAP.
- Abort semantics: frame_abort never toggles write_frame and never pulses frameswap.
- Latency: write_req is asserted the cycle after the second pixel of a pair is accepted. The next pixel can be accepted 2 cycles after the ack cycle.
- Gaps: pix_valid gaps in the GATHER states hold all state.
- Reset mid-operation (any state, including WAIT_ACK): next edge returns to the reset state; the pending write is abandoned.
- word_cnt width: ADDR_W-1 bits, with no wrap beyond WORDS-1.

Test Plan:
1. Reset -> hold n_rst=0 for 2 edges, release -> write_req=0, frameswap=0, write_frame=0, pix_ready=1; asynchronous glitch of n_rst between edges has no effect.
2. Single pair -> sof with 0x1111, then 0x2222; n_writedone held high 5 cycles, then low -> write_req one cycle, write_addr=0x00000, write_data=0x22221111, pix_ready=0 until the ack; next pair gets write_addr=0x00001.
3. Full frame (H_ACTIVE=4, V_ACTIVE=2, WORDS=4) -> 8 pixels with immediate acks -> four writes at addresses 0x00000-0x00003, then frameswap one cycle and write_frame=1; next frame writes at 0x40000.
4. Abort -> sof again after 3 words plus 1 pixel -> frame_abort one cycle, no frameswap, next write_addr=0x00000 with the new sof pixel in the low half.
5. Sync/flow -> non-sof pixels in IDLE are dropped with no write_req; pix_valid gaps in GATHER produce no state change; n_writedone=0 during REQUEST is ignored (ack only counted in WAIT_ACK).
6. Reset in WAIT_ACK after write_frame=1 -> next edge: IDLE, write_req=0, write_frame=0, word_cnt=0.
